qix_vram_arbiter: RTL and testbench

Single-port VRAM access arbiter for the Qix video board. It shares the 64 KB video RAM between two requesters. The CRTC scan-out fetch has absolute priority. The video CPU (6809E) gets the remaining RAM slots and is stalled through a ready/ack handshake. It sits between the video CPU bus decode, the scan-out pixel fetch and the VRAM macro (synchronous read, 1-cycle latency).

---
 rtl/qix_video_pkg.sv | 22 ++
 rtl/qix_vram_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_qix_vram_arbiter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/qix_video_pkg.sv
// Shared definitions for the Qix video board VRAM path.
// The CPU FSM gains the masked-write states when QIX_VRAM_RMW_EN is defined.
package qix_video_pkg;

  localparam int unsigned QIX_ADDR_W = 16;
  localparam int unsigned QIX_DATA_W = 8;
  localparam int unsigned VRAM_SIZE  = 65536;

  typedef enum logic [2:0] {
    CPU_IDLE,
    CPU_WR,
    CPU_RD,
    CPU_RD_CAP,
`ifdef QIX_VRAM_RMW_EN
    CPU_RMW_RD,
    CPU_RMW_CAP,
    CPU_RMW_WR,
`endif
    CPU_ACK
  } cpu_state_e;

endpackage

// File: rtl/qix_vram_arbiter.sv
// Single-port VRAM arbiter: scan-out fetches take priority over the 6809E video CPU.
// Optional masked read-modify-write CPU writes via QIX_VRAM_RMW_EN.
module qix_vram_arbiter
  import qix_video_pkg::*;
#(
  parameter int unsigned ADDR_W = QIX_ADDR_W,
  parameter int unsigned DATA_W = QIX_DATA_W
) (
  input  logic              clk_20m,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              disp_overrun,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  input  logic [DATA_W-1:0] cpu_mask,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_ack,
  output logic              cpu_wait,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout
);

  cpu_state_e        state, state_nxt;
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_addr;
  logic              disp_rd_d1;
  logic              disp_direct;
  logic              disp_issue;
  logic [ADDR_W-1:0] disp_addr_sel;
  logic              accept;
  logic [ADDR_W-1:0] cpu_addr_q;
  logic [DATA_W-1:0] cpu_din_q;

`ifdef QIX_VRAM_RMW_EN
  logic [DATA_W-1:0] cpu_mask_q;
  logic [DATA_W-1:0] old_q;
  logic [DATA_W-1:0] merged;
  assign merged = (old_q & ~cpu_mask_q) | (cpu_din_q & cpu_mask_q);
`else
  logic mask_unused;
  assign mask_unused = ^cpu_mask;
`endif

  // Fetches are spaced at least two slots apart: a request right after an
  // issued fetch parks in the pending latch and goes out in the next slot.
  always_comb begin
    disp_direct   = !reset && disp_req && !pend_valid && !disp_rd_d1;
    disp_issue    = !reset && (pend_valid || disp_direct);
    disp_addr_sel = pend_valid ? pend_addr : disp_addr;
  end

  always_ff @(posedge clk_20m or posedge reset) begin
    if (reset) begin
      pend_valid   <= 1'b0;
      pend_addr    <= '0;
      disp_rd_d1   <= 1'b0;
      disp_valid   <= 1'b0;
      disp_data    <= '0;
      disp_overrun <= 1'b0;
    end else begin
      disp_rd_d1 <= disp_issue;
      disp_valid <= disp_rd_d1;
      if (disp_rd_d1)
        disp_data <= ram_dout;
      if (disp_req && pend_valid)
        disp_overrun <= 1'b1;
      pend_valid <= disp_req && !pend_valid && disp_rd_d1;
      if (disp_req && !pend_valid && disp_rd_d1)
        pend_addr <= disp_addr;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    cpu_wait  = 1'b0;
    ram_we    = 1'b0;
    ram_din   = '0;
    ram_addr  = disp_issue ? disp_addr_sel : '0;
    unique case (state)
      CPU_IDLE: begin
        if (!reset && cpu_req) begin
          if (disp_issue) begin
            cpu_wait = 1'b1;
          end else begin
            accept = 1'b1;
`ifdef QIX_VRAM_RMW_EN
            if (cpu_we)
              state_nxt = (cpu_mask != '1) ? CPU_RMW_RD : CPU_WR;
            else
              state_nxt = CPU_RD;
`else
            state_nxt = cpu_we ? CPU_WR : CPU_RD;
`endif
          end
        end
      end
      CPU_WR: begin
        if (disp_issue) begin
          cpu_wait = 1'b1;
        end else begin
          ram_addr  = cpu_addr_q;
          ram_din   = cpu_din_q;
          ram_we    = 1'b1;
          state_nxt = CPU_ACK;
        end
      end
      CPU_RD: begin
        if (disp_issue) begin
          cpu_wait = 1'b1;
        end else begin
          ram_addr  = cpu_addr_q;
          state_nxt = CPU_RD_CAP;
        end
      end
      CPU_RD_CAP: state_nxt = CPU_ACK;
`ifdef QIX_VRAM_RMW_EN
      CPU_RMW_RD: begin
        if (disp_issue) begin
          cpu_wait = 1'b1;
        end else begin
          ram_addr  = cpu_addr_q;
          state_nxt = CPU_RMW_CAP;
        end
      end
      CPU_RMW_CAP: state_nxt = CPU_RMW_WR;
      CPU_RMW_WR: begin
        if (disp_issue) begin
          cpu_wait = 1'b1;
        end else begin
          ram_addr  = cpu_addr_q;
          ram_din   = merged;
          ram_we    = 1'b1;
          state_nxt = CPU_ACK;
        end
      end
`endif
      CPU_ACK: state_nxt = CPU_IDLE;
      default: state_nxt = CPU_IDLE;
    endcase
  end

  assign cpu_ack = (state == CPU_ACK);

  always_ff @(posedge clk_20m or posedge reset) begin
    if (reset) begin
      state      <= CPU_IDLE;
      cpu_addr_q <= '0;
      cpu_din_q  <= '0;
      cpu_dout   <= '0;
`ifdef QIX_VRAM_RMW_EN
      cpu_mask_q <= '0;
      old_q      <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        cpu_addr_q <= cpu_addr;
        cpu_din_q  <= cpu_din;
`ifdef QIX_VRAM_RMW_EN
        cpu_mask_q <= cpu_mask;
`endif
      end
      if (state == CPU_RD_CAP)
        cpu_dout <= ram_dout;
`ifdef QIX_VRAM_RMW_EN
      if (state == CPU_RMW_CAP)
        old_q <= ram_dout;
`endif
    end
  end

endmodule

// File: tb/tb_qix_vram_arbiter.sv
// Directed self-checking bench for qix_vram_arbiter with a behavioural VRAM.
// The masked-write case follows QIX_VRAM_RMW_EN.
module tb_qix_vram_arbiter;

  logic        clk_20m = 1'b0;
  logic        reset;
  logic        disp_req;
  logic [15:0] disp_addr;
  logic [7:0]  disp_data;
  logic        disp_valid;
  logic        disp_overrun;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_mask;
  logic [7:0]  cpu_dout;
  logic        cpu_ack;
  logic        cpu_wait;
  logic [15:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic [7:0]  ram_dout;

  logic [7:0]  mem [0:65535];
  logic        pl_we;
  logic [15:0] pl_addr;
  logic [7:0]  pl_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk_20m = ~clk_20m;

  qix_vram_arbiter #(.ADDR_W(16), .DATA_W(8)) dut (
    .clk_20m     (clk_20m),
    .reset       (reset),
    .disp_req    (disp_req),
    .disp_addr   (disp_addr),
    .disp_data   (disp_data),
    .disp_valid  (disp_valid),
    .disp_overrun(disp_overrun),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_din     (cpu_din),
    .cpu_mask    (cpu_mask),
    .cpu_dout    (cpu_dout),
    .cpu_ack     (cpu_ack),
    .cpu_wait    (cpu_wait),
    .ram_addr    (ram_addr),
    .ram_din     (ram_din),
    .ram_we      (ram_we),
    .ram_dout    (ram_dout)
  );

  // Synchronous-read VRAM; the preload port is only used while the DUT is in reset.
  always @(posedge clk_20m) begin
    if (pl_we)
      mem[pl_addr] <= pl_data;
    else if (ram_we)
      mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_20m);
    #2;
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pl_we   = 1'b1;
    pl_addr = a;
    pl_data = d;
    step();
    pl_we   = 1'b0;
  endtask

  task automatic cpu_drive(input logic we, input logic [15:0] a, input logic [7:0] d, input logic [7:0] m);
    cpu_req  = 1'b1;
    cpu_we   = we;
    cpu_addr = a;
    cpu_din  = d;
    cpu_mask = m;
  endtask

  logic [6:0] exp_dv, exp_wait, exp_we, exp_ack;
  int         dv_count;

  initial begin
    reset = 1'b1; disp_req = 1'b0; disp_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0; cpu_mask = 8'hFF;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0;

    preload(16'h0100, 8'h77);
    preload(16'h0200, 8'h33);
    preload(16'h0300, 8'hA1);
    preload(16'h0301, 8'hA2);
    preload(16'h0302, 8'hA3);
    preload(16'h2000, 8'hF0);
    preload(16'h0500, 8'h42);

    // reset state, with requests asserted to show they are ignored
    disp_req = 1'b1; disp_addr = 16'h0300; cpu_drive(1'b1, 16'h1234, 8'h5A, 8'hFF);
    #1;
    check("rst_ram_addr", ram_addr, 16'h0000);
    check("rst_ram_we", ram_we, 1'b0);
    check("rst_cpu_wait", cpu_wait, 1'b0);
    check("rst_cpu_ack", cpu_ack, 1'b0);
    check("rst_disp_valid", disp_valid, 1'b0);
    check("rst_overrun", disp_overrun, 1'b0);
    step();
    reset = 1'b0; disp_req = 1'b0; cpu_req = 1'b0;
    step(); step();

    // plain write, then read-back
    cpu_drive(1'b1, 16'h1234, 8'h5A, 8'hFF);
    #1 check("wr_n0_we", ram_we, 1'b0);
    step();
    cpu_addr = 16'hFFFF; cpu_din = 8'h00;
    #1;
    check("wr_n1_we", ram_we, 1'b1);
    check("wr_n1_addr", ram_addr, 16'h1234);
    check("wr_n1_din", ram_din, 8'h5A);
    check("wr_n1_ack", cpu_ack, 1'b0);
    step();
    cpu_req = 1'b0;
    #1;
    check("wr_n2_ack", cpu_ack, 1'b1);
    check("wr_n2_we", ram_we, 1'b0);
    step();
    cpu_drive(1'b0, 16'h1234, 8'h00, 8'hFF);
    step();
    #1;
    check("rd_n1_addr", ram_addr, 16'h1234);
    check("rd_n1_we", ram_we, 1'b0);
    step();
    #1 check("rd_n2_ack", cpu_ack, 1'b0);
    step();
    cpu_req = 1'b0;
    #1;
    check("rd_n3_ack", cpu_ack, 1'b1);
    check("rd_n3_dout", cpu_dout, 8'h5A);
    step(); step();

    // display and CPU read in the same cycle
    disp_req = 1'b1; disp_addr = 16'h0200; cpu_drive(1'b0, 16'h0100, 8'h00, 8'hFF);
    #1;
    check("co_n0_addr", ram_addr, 16'h0200);
    check("co_n0_wait", cpu_wait, 1'b1);
    step();
    disp_req = 1'b0;
    #1;
    check("co_n1_wait", cpu_wait, 1'b0);
    check("co_n1_addr", ram_addr, 16'h0000);
    step();
    #1;
    check("co_n2_dvalid", disp_valid, 1'b1);
    check("co_n2_ddata", disp_data, 8'h33);
    check("co_n2_addr", ram_addr, 16'h0100);
    step();
    #1;
    check("co_n3_dvalid", disp_valid, 1'b0);
    check("co_n3_ack", cpu_ack, 1'b0);
    step();
    cpu_req = 1'b0;
    #1;
    check("co_n4_ack", cpu_ack, 1'b1);
    check("co_n4_dout", cpu_dout, 8'h77);
    step(); step();

    // three back-to-back display requests against a stalled CPU write
    exp_dv = 7'b0010100; exp_wait = 7'b0000101; exp_we = 7'b0001000; exp_ack = 7'b0010000;
    dv_count = 0;
    for (int i = 0; i < 7; i++) begin
      disp_req  = (i < 3);
      disp_addr = 16'h0300 + 16'(i);
      if (i < 4) cpu_drive(1'b1, 16'h0400, 8'h99, 8'hFF);
      else cpu_req = 1'b0;
      #1;
      check($sformatf("bb_dvalid_%0d", i), disp_valid, exp_dv[i]);
      check($sformatf("bb_wait_%0d", i), cpu_wait, exp_wait[i]);
      check($sformatf("bb_we_%0d", i), ram_we, exp_we[i]);
      check($sformatf("bb_ack_%0d", i), cpu_ack, exp_ack[i]);
      if (disp_valid) dv_count++;
      if (i == 0) check("bb_addr_0", ram_addr, 16'h0300);
      if (i == 2) check("bb_addr_2", ram_addr, 16'h0301);
      if (i == 3) check("bb_addr_3", ram_addr, 16'h0400);
      if (i == 2) check("bb_data_2", disp_data, 8'hA1);
      if (i == 4) check("bb_data_4", disp_data, 8'hA2);
      if (i == 2) check("bb_ovr_2", disp_overrun, 1'b0);
      if (i == 3) check("bb_ovr_3", disp_overrun, 1'b1);
      step();
    end
    check("bb_dv_count", dv_count, 2);
    check("bb_mem_0400", mem[16'h0400], 8'h99);
    check("bb_ovr_sticky", disp_overrun, 1'b1);
    step();

`ifdef QIX_VRAM_RMW_EN
    // masked write with a display fetch between the RAM read and the write
    cpu_drive(1'b1, 16'h2000, 8'h0F, 8'h3C);
    #1 check("rmw_n0_wait", cpu_wait, 1'b0);
    step();
    #1;
    check("rmw_n1_addr", ram_addr, 16'h2000);
    check("rmw_n1_we", ram_we, 1'b0);
    step();
    disp_req = 1'b1; disp_addr = 16'h0300;
    #1;
    check("rmw_n2_addr", ram_addr, 16'h0300);
    check("rmw_n2_wait", cpu_wait, 1'b0);
    step();
    disp_req = 1'b0;
    #1;
    check("rmw_n3_we", ram_we, 1'b1);
    check("rmw_n3_addr", ram_addr, 16'h2000);
    check("rmw_n3_din", ram_din, 8'hCC);
    step();
    cpu_req = 1'b0;
    #1;
    check("rmw_n4_ack", cpu_ack, 1'b1);
    check("rmw_n4_dvalid", disp_valid, 1'b1);
    check("rmw_n4_ddata", disp_data, 8'hA1);
    step();
    check("rmw_mem_2000", mem[16'h2000], 8'hCC);
`else
    // without the masked-write option a partial mask still writes the full byte
    cpu_drive(1'b1, 16'h2000, 8'h0F, 8'h3C);
    step();
    #1;
    check("fw_n1_we", ram_we, 1'b1);
    check("fw_n1_din", ram_din, 8'h0F);
    step();
    cpu_req = 1'b0;
    #1 check("fw_n2_ack", cpu_ack, 1'b1);
    step();
    check("fw_mem_2000", mem[16'h2000], 8'h0F);
`endif
    step();

    // reset in the middle of a write
    cpu_drive(1'b1, 16'h0500, 8'h11, 8'hFF);
    step();
    reset = 1'b1; disp_req = 1'b1; disp_addr = 16'h0300;
    #1;
    check("ra_we", ram_we, 1'b0);
    check("ra_ack", cpu_ack, 1'b0);
    check("ra_addr", ram_addr, 16'h0000);
    check("ra_din", ram_din, 8'h00);
    check("ra_wait", cpu_wait, 1'b0);
    check("ra_ovr", disp_overrun, 1'b0);
    check("ra_dvalid", disp_valid, 1'b0);
    check("ra_ddata", disp_data, 8'h00);
    check("ra_dout", cpu_dout, 8'h00);
    step();
    reset = 1'b0; disp_req = 1'b0; cpu_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("ra_post_ack_%0d", i), cpu_ack, 1'b0);
      step();
    end
    check("ra_mem_0500", mem[16'h0500], 8'h42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
